// File: rtl/matrix_pkg.sv
// Shared types and constants for the matrix feeder and its operand buffers.
package matrix_pkg;

  // Operand, product and accumulator width used when the top is not overridden.
  localparam int DEFAULT_DATA_W = 32;

  // Sequencer phases: idle, issuing operand pairs, waiting for the core, final pulse.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_e;

  // Host buffer select encodings.
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/matrix_operand_buf.sv
// N*N x DATA_W operand store: one synchronous write port, one combinational read port.
// Contents are deliberately not reset; the host loads them before each computation.
module matrix_operand_buf #(
  parameter int N      = 4,
  parameter int DATA_W = 32,
  parameter int AW     = $clog2(N * N)
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [N*N];

  // Store a host element on the clock edge when the write strobe is accepted.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read is combinational so the issue counters address the operand in the same cycle.
  always_comb begin
    rd_data_o = mem_q[rd_addr_i];
  end

endmodule

// File: rtl/matrix_feeder.sv
// Sequencer for the single-MAC matrix core: streams A/B operand pairs for C = A x B,
// strobes the accumulator clear one cycle behind each new dot product, and captures
// every finished dot product from the core into a result stream.
module matrix_feeder
  import matrix_pkg::*;
#(
  parameter int N      = 4,
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int AW     = $clog2(N * N)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   wr_en_i,
  input  logic                   wr_sel_i,
  input  logic [AW-1:0]          wr_addr_i,
  input  logic [DATA_W-1:0]      wr_data_i,
  input  logic                   start_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [DATA_W-1:0]      core_a_o,
  output logic [DATA_W-1:0]      core_b_o,
  output logic                   core_m_rst_o,
  input  logic [DATA_W-1:0]      core_acc_i,
  output logic                   res_valid_o,
  output logic [$clog2(N)-1:0]   res_row_o,
  output logic [$clog2(N)-1:0]   res_col_o,
  output logic [DATA_W-1:0]      res_data_o
);

  localparam int              RW       = $clog2(N);
  localparam logic [RW-1:0]   LAST_IDX = RW'(N - 1);
  localparam logic [AW-1:0]   N_AW     = AW'(N);

  // Sequencer state and issue counters (i outer, j middle, k inner).
  state_e          state_q;
  logic            busy_q;
  logic            drainCnt_q;
  logic [RW-1:0]   rowIdx_q, colIdx_q, kIdx_q;
  logic [RW-1:0]   rowIdx_d, colIdx_d, kIdx_d;
  logic            lastIssue;
  logic            streaming;

  // Operand buffer plumbing.
  logic            wrEnA, wrEnB;
  logic [AW-1:0]   rdAddrA, rdAddrB;
  logic [DATA_W-1:0] rdDataA, rdDataB;

  // Clear strobe and capture pipeline (two stages to match product register + accumulate).
  logic            mRst_q;
  logic            cap1_q, cap2_q;
  logic [RW-1:0]   row1_q, col1_q, row2_q, col2_q;

  // Result registers.
  logic            resValid_q;
  logic            done_q;
  logic [RW-1:0]   resRow_q, resCol_q;
  logic [DATA_W-1:0] resData_q;

  assign streaming = (state_q == STREAM);

  // Host writes land only while idle; a write alongside start is committed before cycle 0 reads it.
  assign wrEnA = wr_en_i && !busy_q && (wr_sel_i == SEL_A);
  assign wrEnB = wr_en_i && !busy_q && (wr_sel_i == SEL_B);

  // A is walked along row i, B down column j; both indexed by the inner k counter.
  assign rdAddrA = (AW'(rowIdx_q) * N_AW) + AW'(kIdx_q);
  assign rdAddrB = (AW'(kIdx_q) * N_AW) + AW'(colIdx_q);

  matrix_operand_buf #(
    .N      (N),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_buf_a (
    .clk_i     (clk_i),
    .wr_en_i   (wrEnA),
    .wr_addr_i (wr_addr_i),
    .wr_data_i (wr_data_i),
    .rd_addr_i (rdAddrA),
    .rd_data_o (rdDataA)
  );

  matrix_operand_buf #(
    .N      (N),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_buf_b (
    .clk_i     (clk_i),
    .wr_en_i   (wrEnB),
    .wr_addr_i (wr_addr_i),
    .wr_data_i (wr_data_i),
    .rd_addr_i (rdAddrB),
    .rd_data_o (rdDataB)
  );

  // Nested i/j/k increment with wrap; lastIssue marks the final operand pair of the run.
  always_comb begin
    rowIdx_d  = rowIdx_q;
    colIdx_d  = colIdx_q;
    kIdx_d    = kIdx_q;
    lastIssue = (rowIdx_q == LAST_IDX) && (colIdx_q == LAST_IDX) && (kIdx_q == LAST_IDX);
    if (kIdx_q == LAST_IDX) begin
      kIdx_d = '0;
      if (colIdx_q == LAST_IDX) begin
        colIdx_d = '0;
        if (rowIdx_q == LAST_IDX) begin
          rowIdx_d = '0;
        end else begin
          rowIdx_d = rowIdx_q + RW'(1);
        end
      end else begin
        colIdx_d = colIdx_q + RW'(1);
      end
    end else begin
      kIdx_d = kIdx_q + RW'(1);
    end
  end

  // Main FSM: IDLE -> STREAM (N^3 cycles) -> DRAIN (2 cycles) -> FINISH (1 cycle) -> IDLE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      drainCnt_q <= 1'b0;
      rowIdx_q   <= '0;
      colIdx_q   <= '0;
      kIdx_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q  <= STREAM;
            busy_q   <= 1'b1;
            rowIdx_q <= '0;
            colIdx_q <= '0;
            kIdx_q   <= '0;
          end
        end
        STREAM: begin
          rowIdx_q <= rowIdx_d;
          colIdx_q <= colIdx_d;
          kIdx_q   <= kIdx_d;
          if (lastIssue) begin
            state_q    <= DRAIN;
            drainCnt_q <= 1'b0;
          end
        end
        DRAIN: begin
          if (drainCnt_q) begin
            state_q    <= FINISH;
            drainCnt_q <= 1'b0;
          end else begin
            drainCnt_q <= 1'b1;
          end
        end
        FINISH: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Clear strobe trails k==0 by one cycle; capture flag trails k==N-1 by two cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mRst_q <= 1'b0;
      cap1_q <= 1'b0;
      cap2_q <= 1'b0;
      row1_q <= '0;
      col1_q <= '0;
      row2_q <= '0;
      col2_q <= '0;
    end else begin
      mRst_q <= streaming && (kIdx_q == '0);
      cap1_q <= streaming && (kIdx_q == LAST_IDX);
      row1_q <= rowIdx_q;
      col1_q <= colIdx_q;
      cap2_q <= cap1_q;
      row2_q <= row1_q;
      col2_q <= col1_q;
    end
  end

  // Sample the completed accumulator before the next clear takes effect, and pulse done on the last one.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resValid_q <= 1'b0;
      done_q     <= 1'b0;
      resRow_q   <= '0;
      resCol_q   <= '0;
      resData_q  <= '0;
    end else begin
      resValid_q <= cap2_q;
      done_q     <= cap2_q && (row2_q == LAST_IDX) && (col2_q == LAST_IDX);
      if (cap2_q) begin
        resRow_q  <= row2_q;
        resCol_q  <= col2_q;
        resData_q <= core_acc_i;
      end
    end
  end

  assign core_a_o     = streaming ? rdDataA : '0;
  assign core_b_o     = streaming ? rdDataB : '0;
  assign core_m_rst_o = mRst_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign res_valid_o  = resValid_q;
  assign res_row_o    = resRow_q;
  assign res_col_o    = resCol_q;
  assign res_data_o   = resData_q;

endmodule

// File: tb/tb_matrix_feeder.sv
// Self-checking bench for matrix_feeder with a behavioural single-MAC core attached.
module tb_matrix_feeder;

  localparam int N      = 4;
  localparam int DATA_W = 32;
  localparam int AW     = 4;
  localparam int RW     = 2;
  localparam int NN     = N * N;
  localparam int N3     = N * N * N;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_en = 1'b0;
  logic              wr_sel = 1'b0;
  logic [AW-1:0]     wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              start = 1'b0;
  logic              busy, done, core_m_rst, res_valid;
  logic [DATA_W-1:0] core_a, core_b, res_data;
  logic [RW-1:0]     res_row, res_col;
  logic [DATA_W-1:0] coreProd = '0;
  logic [DATA_W-1:0] coreAcc = '0;

  logic [DATA_W-1:0] modelA [NN];
  logic [DATA_W-1:0] modelB [NN];
  logic [DATA_W-1:0] expC   [NN];
  int                lastRow, lastCol;
  logic [DATA_W-1:0] lastData;

  int checks = 0;
  int errors = 0;

  matrix_feeder #(
    .N      (N),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .wr_en_i      (wr_en),
    .wr_sel_i     (wr_sel),
    .wr_addr_i    (wr_addr),
    .wr_data_i    (wr_data),
    .start_i      (start),
    .busy_o       (busy),
    .done_o       (done),
    .core_a_o     (core_a),
    .core_b_o     (core_b),
    .core_m_rst_o (core_m_rst),
    .core_acc_i   (coreAcc),
    .res_valid_o  (res_valid),
    .res_row_o    (res_row),
    .res_col_o    (res_col),
    .res_data_o   (res_data)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Core model: one-cycle product register, accumulator loads instead of adding when m_rst is high.
  always @(posedge clk) begin
    coreProd <= core_a * core_b;
    if (core_m_rst) coreAcc <= coreProd;
    else            coreAcc <= coreAcc + coreProd;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference C = A x B with DATA_W wraparound on every product and sum.
  task automatic computeExpected();
    logic [DATA_W-1:0] sum, prod;
    for (int d = 0; d < NN; d++) begin
      sum = '0;
      for (int k = 0; k < N; k++) begin
        prod = modelA[(d / N) * N + k] * modelB[k * N + (d % N)];
        sum  = sum + prod;
      end
      expC[d] = sum;
    end
  endtask

  // Load both buffers from the model arrays; called and returns at a falling edge.
  task automatic applyStimulus();
    for (int idx = 0; idx < NN; idx++) begin
      for (int s = 0; s < 2; s++) begin
        wr_en   = 1'b1;
        wr_sel  = s[0];
        wr_addr = AW'(idx);
        wr_data = (s == 0) ? modelA[idx] : modelB[idx];
        @(negedge clk);
      end
    end
    wr_en = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ":busy"},      busy,       0);
    checkOutput({tag, ":done"},      done,       0);
    checkOutput({tag, ":res_valid"}, res_valid,  0);
    checkOutput({tag, ":m_rst"},     core_m_rst, 0);
    checkOutput({tag, ":core_a"},    core_a,     0);
    checkOutput({tag, ":core_b"},    core_b,     0);
    checkOutput({tag, ":res_row"},   res_row,    0);
    checkOutput({tag, ":res_col"},   res_col,    0);
    checkOutput({tag, ":res_data"},  res_data,   0);
  endtask

  // Expected outputs for cycle c of a run, derived from cycle arithmetic over i/j/k order.
  task automatic checkCycle(input int c);
    logic expBusy, expDone, expValid, expMrst;
    logic [DATA_W-1:0] expA, expB;
    int d;
    expBusy  = (c <= N3 + 2);
    expDone  = (c == N3 + 2);
    expValid = (c >= N + 2) && (c <= N3 + 2) && (((c - N - 2) % N) == 0);
    expMrst  = (c >= 1) && (c <= N3 - N + 1) && (((c - 1) % N) == 0);
    if (c < N3) begin
      expA = modelA[(c / NN) * N + (c % N)];
      expB = modelB[(c % N) * N + ((c / N) % N)];
    end else begin
      expA = '0;
      expB = '0;
    end
    if (expValid) begin
      d        = (c - N - 2) / N;
      lastRow  = d / N;
      lastCol  = d % N;
      lastData = expC[d];
    end
    checkOutput($sformatf("busy@%0d", c),      busy,       expBusy);
    checkOutput($sformatf("done@%0d", c),      done,       expDone);
    checkOutput($sformatf("res_valid@%0d", c), res_valid,  expValid);
    checkOutput($sformatf("m_rst@%0d", c),     core_m_rst, expMrst);
    checkOutput($sformatf("core_a@%0d", c),    core_a,     expA);
    checkOutput($sformatf("core_b@%0d", c),    core_b,     expB);
    checkOutput($sformatf("res_row@%0d", c),   res_row,    64'(lastRow));
    checkOutput($sformatf("res_col@%0d", c),   res_col,    64'(lastCol));
    checkOutput($sformatf("res_data@%0d", c),  res_data,   lastData);
  endtask

  // One run: optional write in the start cycle, optional busy-time disturbance, optional abort.
  task automatic runAndCheck(input bit disturb, input bit sameWrite, input int abortAt);
    int a;
    if (sameWrite) begin
      a       = int'($urandom_range(NN - 1, 0));
      wr_en   = 1'b1;
      wr_sel  = 1'($urandom);
      wr_addr = AW'(a);
      wr_data = $urandom;
      if (wr_sel) modelB[a] = wr_data;
      else        modelA[a] = wr_data;
    end
    computeExpected();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wr_en = 1'b0;
    for (int c = 0; c <= N3 + 5; c++) begin
      if (c == abortAt) begin
        rst_n = 1'b0;
        #1;
        lastRow = 0; lastCol = 0; lastData = '0;
        checkAllZero("abort");
        for (int r = 0; r < 2; r++) begin
          @(negedge clk);
          checkAllZero($sformatf("abort_hold%0d", r));
        end
        rst_n = 1'b1;
        for (int r = 0; r < 4; r++) begin
          @(negedge clk);
          checkAllZero($sformatf("abort_post%0d", r));
        end
        return;
      end
      checkCycle(c);
      if (disturb && c >= 2 && c <= 58) begin
        wr_en   = 1'b1;
        wr_sel  = 1'($urandom);
        wr_addr = AW'($urandom_range(NN - 1, 0));
        wr_data = $urandom;
        start   = 1'b1;
      end else if (disturb && c == 59) begin
        wr_en = 1'b0;
        start = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    lastRow = 0; lastCol = 0; lastData = '0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    checkAllZero("post_reset");

    $display("[TB] identity A times counting B");
    for (int e = 0; e < NN; e++) begin
      modelA[e] = ((e / N) == (e % N)) ? 32'd1 : 32'd0;
      modelB[e] = DATA_W'(e + 1);
    end
    applyStimulus();
    runAndCheck(1'b0, 1'b0, -1);

    $display("[TB] all twos");
    for (int e = 0; e < NN; e++) begin modelA[e] = 32'd2; modelB[e] = 32'd2; end
    applyStimulus();
    runAndCheck(1'b0, 1'b0, -1);

    $display("[TB] product wrap to zero, then all ones");
    for (int e = 0; e < NN; e++) begin modelA[e] = 32'h0001_0000; modelB[e] = 32'h0001_0000; end
    applyStimulus();
    runAndCheck(1'b0, 1'b0, -1);
    for (int e = 0; e < NN; e++) begin modelA[e] = 32'hFFFF_FFFF; modelB[e] = 32'hFFFF_FFFF; end
    applyStimulus();
    runAndCheck(1'b0, 1'b0, -1);

    $display("[TB] random operands with writes and start while busy, then rerun");
    for (int e = 0; e < NN; e++) begin modelA[e] = $urandom; modelB[e] = $urandom; end
    applyStimulus();
    runAndCheck(1'b1, 1'b0, -1);
    runAndCheck(1'b0, 1'b0, -1);

    $display("[TB] start-cycle write, reset abort at cycle 20, fresh run");
    for (int e = 0; e < NN; e++) begin
      modelA[e] = DATA_W'($urandom_range(1000, 0));
      modelB[e] = DATA_W'($urandom_range(1000, 0));
    end
    applyStimulus();
    runAndCheck(1'b0, 1'b1, 20);
    runAndCheck(1'b0, 1'b1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_feeder.md
Name: matrix_feeder

Overview:
Upstream sequencer for the single-MAC matrix core. It holds two NxN operand matrices A and B loaded by the host. On start it streams the operand pairs for C = A x B into the core's a/b inputs, with the core's accumulator-clear strobe aligned to the core's one-cycle product register. It captures each finished dot product from the core's acc output and emits it as a result stream.

Parameters:
N, 4, matrix dimension; must be >= 2.
DATA_W, 32, operand, product and accumulator width.
AW, clog2(N*N), element address width.

Ports:
clk  in  1  clock.
rst_n  in  1  asynchronous active-low reset.
wr_en  in  1  host write strobe.
wr_sel  in  1  0 = A buffer, 1 = B buffer.
wr_addr  in  AW  row-major element index (row*N + col).
wr_data  in  DATA_W  element value.
start  in  1  begin computation; level is sampled each cycle.
busy  out  1  computation in progress.
done  out  1  one-cycle pulse with the final result.
core_a  out  DATA_W  to core a.
core_b  out  DATA_W  to core b.
core_m_rst  out  1  to core m_rst (accumulator load-instead-of-add).
core_acc  in  DATA_W  from core acc.
res_valid  out  1  result strobe; there is no backpressure.
res_row  out  clog2(N)  result row i.
res_col  out  clog2(N)  result column j.
res_data  out  DATA_W  C[i][j], modulo 2^DATA_W.

Behaviour:
- Reset (async assert, sync release): FSM goes to IDLE. busy, done, res_valid, core_m_rst, core_a, core_b, res_row, res_col and res_data are all 0. Buffer contents are not reset; the host must load both buffers before start.
- FSM states:
  - IDLE: on start=1, go to STREAM; busy=1 from the next cycle.
  - STREAM: N^3 issue cycles.
  - DRAIN: 2 cycles.
  - FINISH: 1 cycle; then back to IDLE.
- Cycle numbering: cycle 0 is the first STREAM cycle, the cycle after start was sampled.
- Issue order in STREAM cycle s: i outer, j middle, k inner. Drive core_a = A[i*N+k] and core_b = B[k*N+j].
- core_a and core_b are 0 in every non-STREAM cycle.
- core_m_rst is high in cycle s+1 exactly when k==0 in cycle s. It is a registered delay, because the core's product register lags its inputs by one cycle. Otherwise core_m_rst is 0.
- Dot product d = i*N+j (pairs dN..dN+N-1) is complete on core_acc in cycle dN+N+1.
  - The feeder registers it at the end of that cycle.
  - res_valid=1 with res_row=i, res_col=j, res_data=sum in cycle dN+N+2.
- Consecutive results are exactly N cycles apart, with no bubbles between dot products. The next dot product's clear strobe coincides with the capture cycle; capture samples core_acc before that clock edge.
- The final result (d=N^2-1) appears in cycle N^3+2. done=1 in that same cycle; busy=0 from cycle N^3+3.
- res_valid and done are single-cycle pulses. res_row, res_col and res_data hold their values between pulses.
- Arithmetic: the core truncates products to DATA_W bits and wraps on accumulation; the feeder performs no saturation.
- Host writes:
  - Accepted only when busy=0; writes while busy are ignored.
  - A write and a start in the same IDLE cycle: the write completes first and is visible to the computation.
- start while busy is ignored; no queuing.
- Asynchronous reset mid-operation aborts immediately. Every output returns to its reset value, and no further res_valid occurs. The core accumulator is left stale; it is harmless because the next run clears it with its first strobe.

Decomposition:
- Package matrix_pkg holds:
  - DATA_W default;
  - the state enum (IDLE, STREAM, DRAIN, FINISH);
  - the wr_sel encodings SEL_A=0 and SEL_B=1.
- Sub-module matrix_operand_buf: an N*N x DATA_W register file with one synchronous write port and one combinational read port, instantiated twice (A and B).
- Index counters (i, j, k), the capture pipeline and the FSM stay in matrix_feeder.

Test Plan:
1. N=4, A=identity, B[k][j]=4k+j+1, bench instantiates the core -> 16 results, C[i][j]=4i+j+1, in row-major order.
2. A and B all 2 -> every res_data=16; first res_valid in cycle 6, then cycles 10, 14, ...; done with the last result in cycle 66; busy low in cycle 67.
3. A and B all 0x0001_0000 -> every product wraps to 0 and every res_data=0. Then A and B all 0xFFFF_FFFF -> each product is 1, every res_data=4.
4. Writes with new values and start=1 while busy -> results match the original matrices and no second run occurs. After done, a fresh start reruns and produces the identical sequence.
5. rst_n low at cycle 20 of a run -> busy, res_valid and core_m_rst drop immediately and stay 0. After release, a new start gives correct results from the stale-accumulator state.
6. Check core_m_rst alignment -> high exactly in cycles 1, 5, 9, ..., 61 for N=4; core_a and core_b are 0 outside STREAM.
